// File: rtl/udp_pkg.sv
// Shared types and widths for the UDP tx arbiter.
package udp_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_fsm_e;

   localparam int UDP_DATA_W = 16;
   localparam int UDP_LEN_W  = $clog2(UDP_DATA_W / 8);

endpackage

// File: rtl/udp_tx_arb_rr_pick.sv
// rr_pick: combinational round-robin search, first set request at or after the pointer.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int REQ_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [REQ_W-1:0] ptr_i,
   output logic             any_o,
   output logic [REQ_W-1:0] idx_o
);

   logic [N_REQ-1:0] w_rot;
   logic [REQ_W:0]   w_sum;

   // w_rot[k] corresponds to requester (ptr_i + k) mod N_REQ
   assign w_rot = N_REQ'({req_i, req_i} >> ptr_i);

   always_comb begin
      any_o = 1'b0;
      w_sum = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            any_o = 1'b1;
            w_sum = {1'b0, ptr_i} + (REQ_W+1)'(k);
         end
      end
      if (w_sum >= (REQ_W+1)'(N_REQ))
         idx_o = REQ_W'(w_sum - (REQ_W+1)'(N_REQ));
      else
         idx_o = w_sum[REQ_W-1:0];
   end

endmodule

// File: rtl/udp_tx_arb.sv
// udp_tx_arb: packet-granular round-robin arbiter for the shared UDP tx datapath.
// Define UDP_TX_ARB_TIMEOUT_EN to add the grant watchdog (limit TO_CNT cycles).
module udp_tx_arb
   import udp_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = UDP_DATA_W,
   parameter int LEN_W  = $clog2(DATA_W / 8),
   parameter int REQ_W  = $clog2(N_REQ),
   parameter int TO_CNT = 255
) (
   input  logic                    clk,
   input  logic                    nreset,
   input  logic [N_REQ-1:0]        req_valid_i,
   input  logic [N_REQ-1:0]        req_start_i,
   input  logic [N_REQ-1:0]        req_last_i,
   input  logic [N_REQ*DATA_W-1:0] req_data_i,
   input  logic [N_REQ*LEN_W-1:0]  req_len_i,
   output logic [N_REQ-1:0]        req_ready_o,
   input  logic                    cancel_i,
   input  logic                    ready_i,
   output logic                    valid_o,
   output logic                    start_o,
   output logic                    last_o,
   output logic [DATA_W-1:0]       data_o,
   output logic [LEN_W-1:0]        len_o,
   output logic [REQ_W-1:0]        gnt_id_o,
   output logic                    busy_o,
   output logic                    err_o
);

   arb_fsm_e          r_state;
   arb_fsm_e          w_state_next;
   logic [REQ_W-1:0]  r_ptr;
   logic [REQ_W-1:0]  r_gnt;
   logic [N_REQ-1:0]  w_elig;
   logic              w_pick_any;
   logic [REQ_W-1:0]  w_pick_idx;
   logic [REQ_W-1:0]  w_sel;
   logic              w_sel_ok;
   logic              w_sel_valid;
   logic              w_sel_start;
   logic              w_sel_last;
   logic [DATA_W-1:0] w_sel_data;
   logic [LEN_W-1:0]  w_sel_len;
   logic              w_valid;
   logic              w_accept;
   logic              w_proto_err;
   logic              w_to_hit;
   logic              w_release;
   logic [DATA_W-1:0] w_data_arr [N_REQ];
   logic [LEN_W-1:0]  w_len_arr  [N_REQ];

   function automatic logic [REQ_W-1:0] f_next(input logic [REQ_W-1:0] x);
      return (x == REQ_W'(N_REQ - 1)) ? '0 : x + REQ_W'(1);
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_req
         assign w_data_arr[gi]  = req_data_i[gi*DATA_W +: DATA_W];
         assign w_len_arr[gi]   = req_len_i[gi*LEN_W +: LEN_W];
         assign req_ready_o[gi] = nreset & w_accept & (w_sel == REQ_W'(gi));
      end
   endgenerate

   assign w_elig = req_valid_i & req_start_i;

   rr_pick #(
      .N_REQ (N_REQ),
      .REQ_W (REQ_W)
   ) u_pick (
      .req_i (w_elig),
      .ptr_i (r_ptr),
      .any_o (w_pick_any),
      .idx_o (w_pick_idx)
   );

   // IDLE shows the round-robin winner combinationally; GRANT locks onto gnt_q
   always_comb begin
      w_sel_ok    = (r_state == ARB_GRANT) | w_pick_any;
      w_sel       = (r_state == ARB_GRANT) ? r_gnt : w_pick_idx;
      w_sel_valid = w_sel_ok & req_valid_i[w_sel];
      w_sel_start = req_start_i[w_sel];
      w_sel_last  = req_last_i[w_sel];
      w_sel_data  = w_data_arr[w_sel];
      w_sel_len   = w_len_arr[w_sel];
      w_valid     = w_sel_valid & ~cancel_i;
      w_accept    = w_valid & ready_i;
      w_proto_err = (r_state == ARB_GRANT) & w_accept & w_sel_start;
   end

   assign w_release = (r_state == ARB_GRANT) & (cancel_i | w_to_hit | (w_accept & w_sel_last));

`ifdef UDP_TX_ARB_TIMEOUT_EN
   localparam int              TO_W   = $clog2(TO_CNT + 1);
   localparam logic [TO_W-1:0] TO_LIM = TO_W'(TO_CNT - 1);
   logic [TO_W-1:0] r_to_cnt;

   // fires on the TO_CNT-th consecutive cycle without an accepted beat
   assign w_to_hit = (r_state == ARB_GRANT) & ~w_accept & (r_to_cnt == TO_LIM);

   always_ff @(posedge clk) begin
      if (!nreset)
         r_to_cnt <= '0;
      else if (r_state != ARB_GRANT || w_accept || w_to_hit)
         r_to_cnt <= '0;
      else
         r_to_cnt <= r_to_cnt + TO_W'(1);
   end
`else
   assign w_to_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!nreset)
         r_state <= ARB_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ARB_IDLE:  if (w_accept && !w_sel_last) w_state_next = ARB_GRANT;
         ARB_GRANT: if (w_release)               w_state_next = ARB_IDLE;
         default:                                w_state_next = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_ptr <= '0;
         r_gnt <= '0;
      end else if (r_state == ARB_IDLE && w_accept) begin
         r_gnt <= w_pick_idx;
         if (w_sel_last)
            r_ptr <= f_next(w_pick_idx);
      end else if (w_release) begin
         r_ptr <= f_next(r_gnt);
      end
   end

   always_comb begin
      valid_o  = nreset & w_valid;
      start_o  = nreset & w_valid & w_sel_start;
      last_o   = nreset & w_valid & w_sel_last;
      data_o   = (nreset && w_sel_ok) ? w_sel_data : '0;
      len_o    = (nreset && w_sel_ok) ? w_sel_len  : '0;
      gnt_id_o = (nreset && w_sel_ok) ? w_sel      : '0;
      busy_o   = nreset & (r_state == ARB_GRANT);
      err_o    = nreset & (w_proto_err | w_to_hit);
   end

endmodule

// File: tb/tb_udp_tx_arb.sv
// Directed self-checking bench for udp_tx_arb (timeout scenario active when UDP_TX_ARB_TIMEOUT_EN is defined).
module tb_udp_tx_arb;

   logic        clk = 1'b0;
   logic        nreset;
   logic [3:0]  req_valid;
   logic [3:0]  req_start;
   logic [3:0]  req_last;
   logic [15:0] rdata [4];
   logic [63:0] req_data;
   logic [3:0]  req_len;
   logic [3:0]  req_ready;
   logic        cancel;
   logic        ready;
   logic        valid_o;
   logic        start_o;
   logic        last_o;
   logic [15:0] data_o;
   logic [0:0]  len_o;
   logic [1:0]  gnt_id;
   logic        busy;
   logic        err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   assign req_data = {rdata[3], rdata[2], rdata[1], rdata[0]};

   udp_tx_arb #(
      .N_REQ  (4),
      .DATA_W (16),
      .LEN_W  (1),
      .REQ_W  (2),
      .TO_CNT (8)
   ) dut (
      .clk         (clk),
      .nreset      (nreset),
      .req_valid_i (req_valid),
      .req_start_i (req_start),
      .req_last_i  (req_last),
      .req_data_i  (req_data),
      .req_len_i   (req_len),
      .req_ready_o (req_ready),
      .cancel_i    (cancel),
      .ready_i     (ready),
      .valid_o     (valid_o),
      .start_o     (start_o),
      .last_o      (last_o),
      .data_o      (data_o),
      .len_o       (len_o),
      .gnt_id_o    (gnt_id),
      .busy_o      (busy),
      .err_o       (err)
   );

   task automatic clr_all();
      req_valid = '0;
      req_start = '0;
      req_last  = '0;
      req_len   = '0;
      for (int i = 0; i < 4; i++) rdata[i] = 16'h0000;
   endtask

   task automatic set_beat(input logic [1:0] r, input logic s, input logic l, input logic [15:0] d);
      req_valid[r] = 1'b1;
      req_start[r] = s;
      req_last[r]  = l;
      rdata[r]     = d;
      req_len[r]   = d[0];
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      nreset = 1'b0;
      clr_all();
      set_beat(2'd1, 1'b1, 1'b0, 16'h1234);
      ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({valid_o, start_o, last_o, busy, err} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_quals: got %b want 00000", {valid_o, start_o, last_o, busy, err});
      end
      n_tests++;
      if (req_ready !== 4'b0000 || data_o !== 16'h0000 || gnt_id !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_data: ready=%b data=%h gnt=%0d want 0000/0000/0", req_ready, data_o, gnt_id);
      end
      next_cycle();
      nreset = 1'b1;
      clr_all();
      next_cycle();
   endtask

   task automatic test_single_packet();
      for (int k = 0; k < 4; k++) begin
         clr_all();
         ready = 1'b1;
         set_beat(2'd2, k == 0, k == 3, 16'hA000 + 16'(k));
         @(negedge clk);
         n_tests++;
         if (gnt_id !== 2'd2 || req_ready !== 4'b0100 || valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant beat%0d: gnt=%0d ready=%b valid=%b want 2/0100/1", k, gnt_id, req_ready, valid_o);
         end
         n_tests++;
         if (data_o !== 16'hA000 + 16'(k) || len_o !== 1'(k)) begin
            n_fail++;
            $display("FAIL single_data beat%0d: data=%h len=%b want %h/%b", k, data_o, len_o, 16'hA000 + 16'(k), 1'(k));
         end
         n_tests++;
         if (busy !== (k != 0) || start_o !== (k == 0) || last_o !== (k == 3)) begin
            n_fail++;
            $display("FAIL single_quals beat%0d: busy=%b start=%b last=%b", k, busy, start_o, last_o);
         end
         next_cycle();
      end
      clr_all();
      @(negedge clk);
      n_tests++;
      if (valid_o !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_idle: valid=%b busy=%b want 0/0", valid_o, busy);
      end
      next_cycle();
      // pointer now 3: requester 3 beats requester 0
      set_beat(2'd0, 1'b1, 1'b1, 16'h0B00);
      set_beat(2'd3, 1'b1, 1'b1, 16'h3B00);
      @(negedge clk);
      n_tests++;
      if (gnt_id !== 2'd3 || req_ready !== 4'b1000 || data_o !== 16'h3B00) begin
         n_fail++;
         $display("FAIL single_ptr: gnt=%0d ready=%b data=%h want 3/1000/3b00", gnt_id, req_ready, data_o);
      end
      next_cycle();
      clr_all();
      next_cycle();
   endtask

   task automatic test_round_robin();
      int beat [4] = '{0, 0, 0, 0};
      int tot  [4] = '{4, 2, 0, 2};
      int exp_req [8] = '{0, 0, 1, 1, 3, 3, 0, 0};
      int e;
      for (int c = 0; c < 8; c++) begin
         clr_all();
         ready = 1'b1;
         for (int r = 0; r < 4; r++)
            if (beat[r] < tot[r])
               set_beat(2'(r), (beat[r] % 2) == 0, (beat[r] % 2) == 1, 16'(r * 256 + beat[r]));
         @(negedge clk);
         e = exp_req[c];
         n_tests++;
         if (gnt_id !== 2'(e) || req_ready !== 4'(1 << e) || data_o !== 16'(e * 256 + beat[e])) begin
            n_fail++;
            $display("FAIL rr_cycle%0d: gnt=%0d ready=%b data=%h want %0d/%b/%h",
                     c, gnt_id, req_ready, data_o, e, 4'(1 << e), 16'(e * 256 + beat[e]));
         end
         for (int r = 0; r < 4; r++)
            if (req_ready[r]) beat[r]++;
         next_cycle();
      end
      clr_all();
      next_cycle();
   endtask

   task automatic test_stall();
      clr_all();
      ready = 1'b1;
      set_beat(2'd1, 1'b1, 1'b0, 16'h1100);
      @(negedge clk);
      n_tests++;
      if (req_ready !== 4'b0010) begin
         n_fail++;
         $display("FAIL stall_first: ready=%b want 0010", req_ready);
      end
      next_cycle();
      for (int s = 0; s < 5; s++) begin
         set_beat(2'd1, 1'b0, 1'b0, 16'h1101);
         ready = 1'b0;
         @(negedge clk);
         n_tests++;
         if (req_ready !== 4'b0000 || valid_o !== 1'b1 || data_o !== 16'h1101 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold%0d: ready=%b valid=%b data=%h busy=%b want 0000/1/1101/1", s, req_ready, valid_o, data_o, busy);
         end
         next_cycle();
      end
      ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (req_ready !== 4'b0010 || data_o !== 16'h1101) begin
         n_fail++;
         $display("FAIL stall_resume: ready=%b data=%h want 0010/1101", req_ready, data_o);
      end
      next_cycle();
      set_beat(2'd1, 1'b0, 1'b1, 16'h1102);
      @(negedge clk);
      n_tests++;
      if (req_ready !== 4'b0010 || last_o !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_last: ready=%b last=%b want 0010/1", req_ready, last_o);
      end
      next_cycle();
      clr_all();
      next_cycle();
   endtask

   task automatic test_cancel();
      // pointer 2: requester 0 wins over requester 1
      clr_all();
      ready = 1'b1;
      set_beat(2'd0, 1'b1, 1'b0, 16'h0C00);
      set_beat(2'd1, 1'b1, 1'b1, 16'h1C00);
      @(negedge clk);
      n_tests++;
      if (gnt_id !== 2'd0 || req_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL cancel_first: gnt=%0d ready=%b want 0/0001", gnt_id, req_ready);
      end
      next_cycle();
      set_beat(2'd0, 1'b0, 1'b0, 16'h0C01);
      cancel = 1'b1;
      @(negedge clk);
      n_tests++;
      if (valid_o !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL cancel_beat: valid=%b ready=%b busy=%b want 0/0000/1", valid_o, req_ready, busy);
      end
      next_cycle();
      cancel = 1'b0;
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || gnt_id !== 2'd1 || req_ready !== 4'b0010 || data_o !== 16'h1C00) begin
         n_fail++;
         $display("FAIL cancel_next: busy=%b gnt=%0d ready=%b data=%h want 0/1/0010/1c00", busy, gnt_id, req_ready, data_o);
      end
      next_cycle();
      clr_all();
      set_beat(2'd0, 1'b0, 1'b0, 16'h0C01);
      @(negedge clk);
      n_tests++;
      if (valid_o !== 1'b0 || req_ready !== 4'b0000) begin
         n_fail++;
         $display("FAIL cancel_nostart: valid=%b ready=%b want 0/0000", valid_o, req_ready);
      end
      next_cycle();
      clr_all();
      set_beat(2'd3, 1'b1, 1'b1, 16'h3C00);
      cancel = 1'b1;
      @(negedge clk);
      n_tests++;
      if (valid_o !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL cancel_idle: valid=%b ready=%b busy=%b want 0/0000/0", valid_o, req_ready, busy);
      end
      next_cycle();
      cancel = 1'b0;
      @(negedge clk);
      n_tests++;
      if (gnt_id !== 2'd3 || req_ready !== 4'b1000) begin
         n_fail++;
         $display("FAIL cancel_idle_release: gnt=%0d ready=%b want 3/1000", gnt_id, req_ready);
      end
      next_cycle();
      clr_all();
      next_cycle();
   endtask

   task automatic test_proto_err();
      clr_all();
      ready = 1'b1;
      set_beat(2'd2, 1'b1, 1'b0, 16'h2F00);
      @(negedge clk);
      n_tests++;
      if (err !== 1'b0 || req_ready !== 4'b0100) begin
         n_fail++;
         $display("FAIL proto_first: err=%b ready=%b want 0/0100", err, req_ready);
      end
      next_cycle();
      set_beat(2'd2, 1'b1, 1'b0, 16'h2F01);
      @(negedge clk);
      n_tests++;
      if (err !== 1'b1 || req_ready !== 4'b0100 || busy !== 1'b1 || start_o !== 1'b1) begin
         n_fail++;
         $display("FAIL proto_err: err=%b ready=%b busy=%b start=%b want 1/0100/1/1", err, req_ready, busy, start_o);
      end
      next_cycle();
      set_beat(2'd2, 1'b0, 1'b1, 16'h2F02);
      @(negedge clk);
      n_tests++;
      if (err !== 1'b0 || req_ready !== 4'b0100 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL proto_keep: err=%b ready=%b busy=%b want 0/0100/1", err, req_ready, busy);
      end
      next_cycle();
      clr_all();
      next_cycle();
   endtask

   task automatic test_reset_mid();
      // pointer 3
      clr_all();
      ready = 1'b1;
      set_beat(2'd3, 1'b1, 1'b0, 16'h3D00);
      @(negedge clk);
      n_tests++;
      if (req_ready !== 4'b1000) begin
         n_fail++;
         $display("FAIL rstmid_first: ready=%b want 1000", req_ready);
      end
      next_cycle();
      nreset = 1'b0;
      set_beat(2'd3, 1'b0, 1'b0, 16'h3D01);
      @(negedge clk);
      n_tests++;
      if (valid_o !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b0 || data_o !== 16'h0000 || gnt_id !== 2'd0) begin
         n_fail++;
         $display("FAIL rstmid_forced: valid=%b ready=%b busy=%b data=%h gnt=%0d want all 0", valid_o, req_ready, busy, data_o, gnt_id);
      end
      next_cycle();
      nreset = 1'b1;
      clr_all();
      set_beat(2'd0, 1'b0, 1'b0, 16'h0D00);
      set_beat(2'd3, 1'b0, 1'b0, 16'h3D01);
      @(negedge clk);
      n_tests++;
      if (valid_o !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_nostart: valid=%b ready=%b busy=%b want 0/0000/0", valid_o, req_ready, busy);
      end
      next_cycle();
      set_beat(2'd1, 1'b1, 1'b1, 16'h1D00);
      set_beat(2'd3, 1'b1, 1'b1, 16'h3D00);
      @(negedge clk);
      n_tests++;
      if (gnt_id !== 2'd1 || req_ready !== 4'b0010) begin
         n_fail++;
         $display("FAIL rstmid_ptr: gnt=%0d ready=%b want 1/0010", gnt_id, req_ready);
      end
      next_cycle();
      clr_all();
      set_beat(2'd0, 1'b1, 1'b1, 16'h0D00);
      @(negedge clk);
      n_tests++;
      if (gnt_id !== 2'd0 || req_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL rstmid_restart: gnt=%0d ready=%b want 0/0001", gnt_id, req_ready);
      end
      next_cycle();
      clr_all();
      next_cycle();
   endtask

   task automatic test_timeout();
      // pointer 1: requester 1 sends one beat then stalls
      clr_all();
      ready = 1'b1;
      set_beat(2'd1, 1'b1, 1'b0, 16'h1E00);
      @(negedge clk);
      n_tests++;
      if (req_ready !== 4'b0010) begin
         n_fail++;
         $display("FAIL to_first: ready=%b want 0010", req_ready);
      end
      next_cycle();
      clr_all();
      set_beat(2'd2, 1'b1, 1'b1, 16'h2E00);
`ifdef UDP_TX_ARB_TIMEOUT_EN
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         n_tests++;
         if (err !== (i == 8) || busy !== 1'b1 || req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL to_wait%0d: err=%b busy=%b ready=%b want %b/1/0000", i, err, busy, req_ready, i == 8);
         end
         next_cycle();
      end
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || gnt_id !== 2'd2 || req_ready !== 4'b0100) begin
         n_fail++;
         $display("FAIL to_next: busy=%b gnt=%0d ready=%b want 0/2/0100", busy, gnt_id, req_ready);
      end
      next_cycle();
`else
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         n_tests++;
         if (err !== 1'b0 || busy !== 1'b1 || req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL hold_wait%0d: err=%b busy=%b ready=%b want 0/1/0000", i, err, busy, req_ready);
         end
         next_cycle();
      end
      set_beat(2'd1, 1'b0, 1'b1, 16'h1E01);
      @(negedge clk);
      n_tests++;
      if (req_ready !== 4'b0010 || last_o !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_last: ready=%b last=%b want 0010/1", req_ready, last_o);
      end
      next_cycle();
      req_valid[1] = 1'b0;
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || gnt_id !== 2'd2 || req_ready !== 4'b0100) begin
         n_fail++;
         $display("FAIL hold_next: busy=%b gnt=%0d ready=%b want 0/2/0100", busy, gnt_id, req_ready);
      end
      next_cycle();
`endif
      clr_all();
      next_cycle();
   endtask

   initial begin
      nreset = 1'b0;
      cancel = 1'b0;
      ready  = 1'b0;
      clr_all();
      test_reset();
      test_single_packet();
      test_round_robin();
      test_stall();
      test_cancel();
      test_proto_err();
      test_reset_mid();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
